// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic inter-stage register: exception codes,
// the default EX/MEM payload layout and the skid-buffer state encoding.
package pipe_stage_elastic_pkg;

    localparam int PC_W = 32;

    // Exception codes carried in exc_code, as used across the pipeline.
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // Default 64-bit EX/MEM payload layout (LSB positions and widths).
    localparam int EXMEM_RESULT_LSB = 0;
    localparam int EXMEM_RESULT_W   = 32;
    localparam int EXMEM_DEST_LSB   = 32;
    localparam int EXMEM_DEST_W     = 5;
    localparam int EXMEM_REGWR_BIT  = 37;
    localparam int EXMEM_MEMRD_BIT  = 38;
    localparam int EXMEM_MEMWR_BIT  = 39;
    localparam int EXMEM_SIZE_LSB   = 40;
    localparam int EXMEM_SIZE_W     = 2;

    // Encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_ONE   = 2'b10,
        SB_FULL  = 2'b11
    } skidState_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready buffer; inReady comes straight from a state bit so the
// upstream ready path is registered.
module pipe_skid_buf
    import pipe_stage_elastic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData
);

    skidState_t   stateReg, stateNext;
    logic [W-1:0] mainReg, skidReg;
    logic         loadMainIn, loadMainSkid, loadSkid;
    logic         accept, emit;

    assign inReady  = !stateReg[0];
    assign outValid = stateReg[1];
    assign outData  = mainReg;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stateReg <= SB_EMPTY;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        accept       = inValid && !stateReg[0];
        emit         = stateReg[1] && outReady;
        case (stateReg)
            SB_EMPTY: begin
                if (accept) begin
                    stateNext  = SB_ONE;
                    loadMainIn = 1'b1;
                end
            end
            SB_ONE: begin
                if (accept && emit) begin
                    loadMainIn = 1'b1;
                end else if (accept) begin
                    stateNext = SB_FULL;
                    loadSkid  = 1'b1;
                end else if (emit) begin
                    stateNext = SB_EMPTY;
                end
            end
            SB_FULL: begin
                if (emit) begin
                    stateNext    = SB_ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: stateNext = SB_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            if (loadMainIn) begin
                mainReg <= inData;
            end else if (loadMainSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= inData;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two stages: valid/ready handshake,
// optional skid buffer, synchronous flush, exception fence and stall counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              in_exc_occur,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic              out_exc_occur,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic              out_bd,
    output logic              fenced,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BUNDLE_W = DATA_W + PC_W + 1 + EXC_W + 1;

    logic [BUNDLE_W-1:0] inBundle, heldBundle, outBundle;
    logic                heldValid, stageReady, acceptFire;
    logic                fencedReg;
    logic [CNT_W-1:0]    stallCntReg;

    assign inBundle   = {in_data, in_pc, in_exc_occur, in_exc_code, in_bd};
    assign in_ready   = stageReady && !fencedReg;
    assign acceptFire = in_valid && in_ready;

    generate
        if (SKID != 0) begin : gSkid
            pipe_skid_buf #(.W(BUNDLE_W)) uBuf (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .inValid  (in_valid && !fencedReg),
                .inReady  (stageReady),
                .inData   (inBundle),
                .outValid (heldValid),
                .outReady (out_ready),
                .outData  (heldBundle)
            );
        end else begin : gSingle
            logic                mainValidReg;
            logic [BUNDLE_W-1:0] mainReg;

            // Ready looks through the register when downstream is draining it.
            assign stageReady = !mainValidReg || out_ready;
            assign heldValid  = mainValidReg;
            assign heldBundle = mainReg;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    mainValidReg <= 1'b0;
                    mainReg      <= '0;
                end else if (acceptFire) begin
                    mainValidReg <= 1'b1;
                    mainReg      <= inBundle;
                end else if (out_ready) begin
                    mainValidReg <= 1'b0;
                end
            end
        end
    endgenerate

    // Bubbles present an all-zero payload so valid-blind consumers see a NOP.
    for (genvar gi = 0; gi < BUNDLE_W; gi++) begin : gZero
        assign outBundle[gi] = heldBundle[gi] & heldValid;
    end

    assign out_valid = heldValid;
    assign {out_data, out_pc, out_exc_occur, out_exc_code, out_bd} = outBundle;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            fencedReg <= 1'b0;
        end else if (acceptFire && in_exc_occur) begin
            fencedReg <= 1'b1;
        end
    end

    // Survives flush so stalls around a pipeline kill are still visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntReg <= '0;
        end else if (heldValid && !out_ready && (stallCntReg != {CNT_W{1'b1}})) begin
            stallCntReg <= stallCntReg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fenced    = fencedReg;
    assign stall_cnt = stallCntReg;

endmodule
